// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle shared by the coefficient input and the zigzag output.
// The master drives payload and tvalid; the slave returns tready.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 8,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1
);
  localparam int TKEEP_WIDTH = (TDATA_WIDTH + 7) / 8;

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic [TKEEP_WIDTH-1:0] tstrb;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest,
    output tready
  );
endinterface

// File: rtl/dct_zigzag_serializer.sv
// Buffers 8x8 DCT blocks (one row per input beat) in a ping-pong pair of banks
// and re-emits each block one coefficient per beat in JPEG zigzag order.
module dct_zigzag_serializer #(
  parameter  int COEF_WIDTH = 12,
  localparam int ZZ_TDATA_W = ((COEF_WIDTH + 7) / 8) * 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  coef_i,
  axi4_stream_if.master zz_o,
  output logic          sync_err_o
);
  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_DRAINING} bank_state_e;
  typedef logic signed [COEF_WIDTH-1:0] coef_t;

  // Zigzag index -> raster address (8*row + col).
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  bank_state_e           state_q [2];
  bank_state_e           state_d [2];
  logic                  sof_q   [2];
  logic                  sof_d   [2];
  coef_t                 bank_q  [2][64];
  logic                  wr_bank_q, wr_bank_d;
  logic [2:0]            wr_row_q,  wr_row_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [5:0]            rd_idx_q,  rd_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [ZZ_TDATA_W-1:0] out_data_q,  out_data_d;
  logic                  out_last_q,  out_last_d;
  logic                  out_user_q,  out_user_d;
  logic                  sync_err_q,  sync_err_d;
  logic                  wr_fire, rd_fire, rd_load;
  coef_t                 rd_coef;
  logic                  unused_sideband;

  assign coef_i.tready = (state_q[wr_bank_q] == BANK_EMPTY) ||
                         (state_q[wr_bank_q] == BANK_FILLING);
  assign wr_fire = coef_i.tvalid && coef_i.tready;
  assign rd_fire = out_valid_q && zz_o.tready;
  assign rd_load = (!out_valid_q || zz_o.tready) &&
                   ((state_q[rd_bank_q] == BANK_FULL) || (state_q[rd_bank_q] == BANK_DRAINING));
  assign rd_coef = bank_q[rd_bank_q][ZZ[rd_idx_q]];

  always_comb begin
    // NOTE: every next-state value gets its default first, so no latch can be inferred.
    state_d     = state_q;
    sof_d       = sof_q;
    wr_bank_d   = wr_bank_q;
    wr_row_d    = wr_row_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_user_d  = out_user_q;
    sync_err_d  = sync_err_q;

    if (wr_fire) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd0) begin
        state_d[wr_bank_q] = BANK_FILLING;
        sof_d[wr_bank_q]   = coef_i.tuser[0];
      end
      if (wr_row_q == 3'd7) begin
        state_d[wr_bank_q] = BANK_FULL;
        wr_bank_d          = ~wr_bank_q;
      end
      if (coef_i.tlast != (wr_row_q == 3'd7)) sync_err_d = 1'b1;
    end

    // rd_bank already moved on when index 63 was loaded, so the finished bank is the other one.
    if (rd_fire && out_last_q) state_d[~rd_bank_q] = BANK_EMPTY;

    if (rd_load) begin
      out_valid_d = 1'b1;
      out_data_d  = ZZ_TDATA_W'(rd_coef);
      out_last_d  = (rd_idx_q == 6'd63);
      out_user_d  = (rd_idx_q == 6'd0) && sof_q[rd_bank_q];
      rd_idx_d    = rd_idx_q + 6'd1;
      if (rd_idx_q == 6'd0)  state_d[rd_bank_q] = BANK_DRAINING;
      if (rd_idx_q == 6'd63) rd_bank_d = ~rd_bank_q;
    end else if (zz_o.tready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q[0]  <= BANK_EMPTY;
      state_q[1]  <= BANK_EMPTY;
      sof_q[0]    <= 1'b0;
      sof_q[1]    <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_row_q    <= 3'd0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= 6'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sof_q       <= sof_d;
      wr_bank_q   <= wr_bank_d;
      wr_row_q    <= wr_row_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // NOTE: the banks have no reset; the bank state alone decides whether their contents are live.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      for (int c = 0; c < 8; c++) begin
        bank_q[wr_bank_q][{wr_row_q, 3'(c)}] <= coef_i.tdata[c*COEF_WIDTH +: COEF_WIDTH];
      end
    end
  end

  assign zz_o.tvalid = out_valid_q;
  assign zz_o.tdata  = out_data_q;
  assign zz_o.tlast  = out_last_q;
  assign zz_o.tuser  = out_user_q;
  assign zz_o.tkeep  = '1;
  assign zz_o.tstrb  = '1;
  assign zz_o.tid    = '0;
  assign zz_o.tdest  = '0;
  assign sync_err_o  = sync_err_q;

  assign unused_sideband = ^{coef_i.tkeep, coef_i.tstrb, coef_i.tid, coef_i.tdest};
endmodule
